// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - state encoding and stream constants shared by the imem loader
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_BYTES      = 2;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// rtl/imem_loader_byte_packer.sv - assembles accepted bytes little-endian into 32-bit words
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        last_lane,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  lane;
  logic [23:0] low;

  assign last_lane = (lane == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane       <= 2'd0;
      low        <= 24'd0;
      word_valid <= 1'b0;
      word       <= 32'd0;
    end else if (clear) begin
      lane       <= 2'd0;
      low        <= 24'd0;
      word_valid <= 1'b0;
      word       <= 32'd0;
    end else begin
      word_valid <= byte_valid && last_lane;
      if (byte_valid) begin
        lane <= lane + 2'd1;
        // The top byte goes straight into the word register; lower lanes wait in low.
        case (lane)
          2'd0:    low[7:0]   <= byte_data;
          2'd1:    low[15:8]  <= byte_data;
          2'd2:    low[23:16] <= byte_data;
          default: word       <= {byte_data, low};
        endcase
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot loader: byte stream to instruction memory, checksum, core reset release
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              start,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              error
);

  localparam int                LEN_W    = 8 * LEN_BYTES;
  localparam int                DEPTH    = 1 << ADDR_W;
  localparam logic [LEN_W:0]    DEPTH_L  = (LEN_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = 1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  state_t            state, state_nx;
  logic              accept;
  logic [7:0]        len_lo;
  logic [LEN_W-1:0]  len_full;
  logic [ADDR_W:0]   words_total;
  logic [ADDR_W:0]   word_cnt;
  logic              last_word;
  logic [7:0]        csum;
  logic              last_lane;
  logic              word_valid;
  logic [31:0]       word;

  assign accept    = in_valid && in_ready;
  assign len_full  = {in_data, len_lo};
  assign last_word = ((word_cnt + CNT_ONE) == words_total);
  assign done      = (state == S_DONE);
  assign error     = (state == S_ERR);
  assign imem_we   = word_valid;
  assign imem_wdata = word;

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (state == S_IDLE),
    .byte_valid (accept && (state == S_DATA)),
    .byte_data  (in_data),
    .last_lane  (last_lane),
    .word_valid (word_valid),
    .word       (word)
  );

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    unique case (state)
      S_IDLE: state_nx = S_LEN0;
      S_LEN0: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = S_LEN1;
      end
      S_LEN1: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if ({1'b0, len_full} > DEPTH_L) state_nx = S_ERR;
          else if (len_full == '0)        state_nx = S_CSUM;
          else                            state_nx = S_DATA;
        end
      end
      S_DATA: begin
        in_ready = 1'b1;
        if (in_valid && last_lane && last_word) state_nx = S_CSUM;
      end
      S_CSUM: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = (in_data == csum) ? S_DONE : S_ERR;
      end
      S_DONE, S_ERR: begin
        if (start) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      cpu_rst     <= 1'b0;
      len_lo      <= 8'd0;
      words_total <= '0;
      word_cnt    <= '0;
      csum        <= 8'd0;
      imem_addr   <= '0;
    end else begin
      state   <= state_nx;
      // Registered so the core sees a clean level that follows the DONE state exactly.
      cpu_rst <= (state_nx == S_DONE);
      if (state == S_IDLE) begin
        word_cnt  <= '0;
        csum      <= 8'd0;
        imem_addr <= '0;
      end else begin
        if (state == S_LEN0 && accept) len_lo <= in_data;
        if (state == S_LEN1 && accept) words_total <= len_full[ADDR_W:0];
        if (state == S_DATA && accept) begin
          csum <= csum ^ in_data;
          if (last_lane) word_cnt <= word_cnt + CNT_ONE;
        end
        if (word_valid) imem_addr <= imem_addr + ADDR_ONE;
      end
    end
  end

endmodule
